// File: rtl/ca_scan.sv
// ca_scan: reads one generation row from the shared row memory and
// serializes it LSB-first, one pixel per active clock.
module ca_scan #(
    parameter int unsigned WORDS = 80,
    parameter int unsigned AW    = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          line_start_i,
    input  logic [AW-1:0] base_i,
    input  logic          active_i,
    output logic          read_o,
    output logic [AW-1:0] raddr_o,
    input  logic [15:0]   rdata_i,
    output logic          pixel_o,
    output logic          de_o,
    output logic          underrun_o
);

    localparam int unsigned CW = $clog2(WORDS + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PRIME0,
        S_PRIME1,
        S_RUN,
        S_DONE
    } state_t;

    state_t          state_q, state_d;
    logic [15:0]     sreg_q, sreg_d;
    logic [15:0]     hold_q, hold_d;
    logic            hold_v_q, hold_v_d;
    logic            first_q, first_d;    // next returning word belongs in sreg
    logic            rvalid_q, rvalid_d;  // rdata carries a word for this line
    logic [3:0]      bit_q, bit_d;
    logic [CW-1:0]   word_q, word_d;
    logic [CW-1:0]   fetch_q, fetch_d;
    logic [AW-1:0]   base_q, base_d;
    logic            read_q, read_d;
    logic [AW-1:0]   raddr_q, raddr_d;
    logic            pixel_q, pixel_d;
    logic            de_q, de_d;
    logic            underrun_q, underrun_d;

    logic            consume_c;
    logic            word_end_c;
    logic            last_word_c;

    // Pixel consumption qualifiers shared by next-state and output logic
    always_comb begin
        consume_c   = (state_q == S_RUN) && active_i && !line_start_i;
        word_end_c  = consume_c && (bit_q == 4'd15);
        last_word_c = word_end_c && (word_q == CW'(WORDS - 1));
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; line_start restarts priming from any state
    always_comb begin
        state_d = state_q;
        if (line_start_i) begin
            state_d = S_PRIME0;
        end else begin
            case (state_q)
                S_PRIME0: state_d = S_PRIME1;
                S_PRIME1: if (rvalid_q && !first_q) state_d = S_RUN;
                S_RUN:    if (last_word_c) state_d = S_DONE;
                default:  state_d = state_q;
            endcase
        end
    end

    // Datapath and registered-output next values
    always_comb begin
        sreg_d     = sreg_q;
        hold_d     = hold_q;
        hold_v_d   = hold_v_q;
        first_d    = first_q;
        rvalid_d   = read_q;
        bit_d      = bit_q;
        word_d     = word_q;
        fetch_d    = fetch_q;
        base_d     = base_q;
        read_d     = 1'b0;
        raddr_d    = raddr_q;
        pixel_d    = 1'b0;
        de_d       = active_i;
        underrun_d = active_i &&
                     (state_q inside {S_IDLE, S_PRIME0, S_PRIME1});

        if (line_start_i) begin
            // Abort: drop buffered words and any read still in flight
            base_d   = base_i;
            read_d   = 1'b1;
            raddr_d  = base_i;
            fetch_d  = CW'(1);
            word_d   = '0;
            bit_d    = '0;
            sreg_d   = '0;
            hold_d   = '0;
            hold_v_d = 1'b0;
            first_d  = 1'b1;
            rvalid_d = 1'b0;
        end else begin
            if (rvalid_q) begin
                if (first_q) begin
                    sreg_d  = rdata_i;
                    first_d = 1'b0;
                end else begin
                    hold_d   = rdata_i;
                    hold_v_d = 1'b1;
                end
            end

            case (state_q)
                S_PRIME0: begin
                    read_d  = 1'b1;
                    raddr_d = base_q + AW'(fetch_q);
                    fetch_d = fetch_q + CW'(1);
                end
                S_RUN: begin
                    if (consume_c) begin
                        pixel_d = sreg_q[0];
                        sreg_d  = {1'b0, sreg_q[15:1]};
                        bit_d   = bit_q + 4'd1;
                        if (word_end_c) begin
                            sreg_d   = hold_v_q ? hold_q : 16'h0000;
                            hold_v_d = 1'b0;
                            word_d   = word_q + CW'(1);
                            if (fetch_q < CW'(WORDS)) begin
                                read_d  = 1'b1;
                                raddr_d = base_q + AW'(fetch_q);
                                fetch_d = fetch_q + CW'(1);
                            end
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Datapath and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sreg_q     <= '0;
            hold_q     <= '0;
            hold_v_q   <= 1'b0;
            first_q    <= 1'b0;
            rvalid_q   <= 1'b0;
            bit_q      <= '0;
            word_q     <= '0;
            fetch_q    <= '0;
            base_q     <= '0;
            read_q     <= 1'b0;
            raddr_q    <= '0;
            pixel_q    <= 1'b0;
            de_q       <= 1'b0;
            underrun_q <= 1'b0;
        end else begin
            sreg_q     <= sreg_d;
            hold_q     <= hold_d;
            hold_v_q   <= hold_v_d;
            first_q    <= first_d;
            rvalid_q   <= rvalid_d;
            bit_q      <= bit_d;
            word_q     <= word_d;
            fetch_q    <= fetch_d;
            base_q     <= base_d;
            read_q     <= read_d;
            raddr_q    <= raddr_d;
            pixel_q    <= pixel_d;
            de_q       <= de_d;
            underrun_q <= underrun_d;
        end
    end

    assign read_o     = read_q;
    assign raddr_o    = raddr_q;
    assign pixel_o    = pixel_q;
    assign de_o       = de_q;
    assign underrun_o = underrun_q;

endmodule

// File: doc/ca_scan.md
# ca_scan

Row scan-out reader for the cellular-automaton display path. It reads one 80-word × 16-bit generation row from the shared row memory and serializes it LSB-first into one pixel per clock for the VESA pixel pipeline. It is the consumer of the rows that `ca_gen` writes, using the same `read`/`raddr`/`rdata` memory port convention.

## Interface
- `WORDS`, 80: words per row; pixels per line = `WORDS`×16.
- `AW`, 8: memory address width.
- `clk`  in  1: pixel clock; all logic on the rising edge.
- `rst`  in  1: asynchronous, active-high reset.
- `line_start`  in  1: one-cycle pulse that latches `base` and begins prefetch for the next line.
- `base`  in  AW: row base address, sampled only when `line_start`=1.
- `active`  in  1: display-enable; each high cycle consumes one pixel.
- `read`  out  1: memory read strobe, registered.
- `raddr`  out  AW: memory read address, registered.
- `rdata`  in  16: read data, valid the cycle after `read`/`raddr` are presented.
- `pixel`  out  1: serialized pixel, registered.
- `de`  out  1: `active` delayed one cycle; qualifies `pixel`.
- `underrun`  out  1: one-cycle pulse when `active` is seen with no primed data.

## Operation
- Storage: 16-bit shift register `sreg`, 16-bit holding register `hold` with a valid flag, 4-bit bit counter, 7-bit word counter, latched `base`.
- States:
  - IDLE: `read`=0. On `line_start`, present `raddr`=`base`, `read`=1, then go to PRIME0.
  - PRIME0: present `raddr`=`base`+1, `read`=1. Capture word 0 into `sreg` on the next edge. Go to PRIME1.
  - PRIME1: `read`=0. Capture word 1 into `hold`. Go to RUN.
  - RUN: on each `active` cycle:
    - `pixel`←`sreg[0]`, `sreg` shifts right, bit counter increments.
    - When the bit counter reaches 15: `sreg`←`hold`, the word counter increments, and if words fetched < `WORDS`, issue a read of the next address. The returned data fills `hold` one cycle after the read.
    - After `WORDS`×16 consumed pixels, go to DONE.
  - DONE: `read`=0 and `pixel`=0 until `line_start`.
- `active` low while in RUN pauses consumption: position is held, `pixel`=0, and pending fetches still complete.
- Address arithmetic is modulo 2^AW: `base`+k wraps (base 200 → 200..255, 0..23).
- Exactly `WORDS` reads per line. Addresses run `base`..`base`+`WORDS`−1, each read once, in order.
- `active` in IDLE, PRIME0, PRIME1 or DONE: `pixel`=0. `underrun`=1 in IDLE/PRIME0/PRIME1 only; DONE is a silent tail with no flag.
- `line_start` in any state, including mid-RUN, aborts the current line, discards `sreg`/`hold`, and restarts priming from the new `base`. `line_start` takes priority over `active` in the same cycle.
- Reset values: `read`=0, `raddr`=0, `pixel`=0, `de`=0, `underrun`=0; state IDLE; all counters and valid flags 0. Reset mid-line abandons the line with no further reads.

## Timing
- With `line_start` in cycle 0:
  - `read`/`raddr`=`base` in cycle 1; `raddr`=`base`+1 in cycle 2.
  - Word 0 valid in cycle 2, word 1 in cycle 3.
  - RUN from cycle 4.
- `active` must first assert no earlier than cycle 4. Assertion in cycles 1–3 produces `underrun`.
- Pixel latency: `active` high in cycle t → `pixel`/`de` valid in cycle t+1.
- Refill: the read for word k+2 is presented in the first cycle of word k+1, and `hold` is valid 2 cycles later. This leaves 14 cycles of slack, so a continuous `active` never starves.
- `underrun` aligns with `de`: it is registered alongside `pixel`.

## Test plan
- Base 0, `active` held 1280 cycles from cycle 4, memory[i]=16'h0001 → `read` sequence: `raddr` 0..79 exactly once each. `pixel`=1 on every 16th `de` cycle starting at the first, 0 otherwise.
- Base 80, memory[80]=16'h8000, memory[81]=16'hFFFF → pixels 0–14=0, pixel 15=1, pixels 16–31=1. Last read `raddr`=159.
- Base 200 → `raddr` 200..255 then 0..23. No read issued after the 80th.
- `active` asserted in cycle 2 after `line_start` → `underrun`=1 and `pixel`=0 in cycle 3. Normal pixels once in RUN.
- `line_start` at pixel 500 with a new `base`=80 → next `read` at 80 one cycle later. Pixel 0 resumes from the word at 80. `underrun` only if `active` is asserted during priming.
- `rst` pulse mid-line → all outputs 0 immediately (asynchronous). No `read` until the next `line_start`.
- `active` gaps: 100 cycles high, 50 low, rest high → a continuous 1280-pixel stream identical to the gap-free run. `pixel`=0 during gaps.
